// File: rtl/sd_cmd_engine.sv
// SD/SDIO command-line engine: serialises a 48-bit command frame with CRC7 and
// collects an optional 48/136-bit response, all timed by a self-generated SD clock.
module sd_cmd_engine #(
  parameter int CLK_DIV      = 34,
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_CYCLES   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         resp_valid,
  output logic [135:0] resp_data,
  output logic         resp_timeout,
  output logic         resp_crc_err,
  output logic         resp_end_err,
  output logic         sd_clk,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = $clog2(RESP_TIMEOUT + 1);
  localparam int NCC_W  = $clog2(NCC_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_NCC  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sd_clk_q, sd_clk_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_timeout_q, resp_timeout_d;
  logic               resp_crc_err_q, resp_crc_err_d;
  logic               resp_end_err_q, resp_end_err_d;
  logic               sd_cmd_o_q, sd_cmd_o_d;
  logic               sd_cmd_oe_q, sd_cmd_oe_d;
  logic [1:0]         rtype_q, rtype_d;
  logic [39:0]        tx_sr_q, tx_sr_d;
  logic [6:0]         tx_crc_q, tx_crc_d;
  logic [5:0]         tx_cnt_q, tx_cnt_d;
  logic [135:0]       rx_sr_q, rx_sr_d;
  logic [6:0]         rx_crc_q, rx_crc_d;
  logic [7:0]         rx_cnt_q, rx_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [NCC_W-1:0]   ncc_cnt_q, ncc_cnt_d;

  logic       tc_s, rise_ev_s, fall_ev_s, rx_crc_en_s;
  logic [7:0] rx_last_s;

  // Divider, transaction FSM and datapath next-state logic.
  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    sd_clk_d       = sd_clk_q;
    cmd_ready_d    = cmd_ready_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = resp_timeout_q;
    resp_crc_err_d = resp_crc_err_q;
    resp_end_err_d = resp_end_err_q;
    sd_cmd_o_d     = sd_cmd_o_q;
    sd_cmd_oe_d    = sd_cmd_oe_q;
    rtype_d        = rtype_q;
    tx_sr_d        = tx_sr_q;
    tx_crc_d       = tx_crc_q;
    tx_cnt_d       = tx_cnt_q;
    rx_sr_d        = rx_sr_q;
    rx_crc_d       = rx_crc_q;
    rx_cnt_d       = rx_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    ncc_cnt_d      = ncc_cnt_q;

    tc_s      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    rise_ev_s = tc_s & ~sd_clk_q;
    fall_ev_s = tc_s & sd_clk_q;
    if (tc_s) begin
      div_cnt_d = '0;
      sd_clk_d  = ~sd_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // R2 protects only the CID/CSD body; short responses protect their first 40 bits.
    rx_last_s = (rtype_q == 2'd2) ? 8'd136 : 8'd48;
    if (rtype_q == 2'd2) begin
      rx_crc_en_s = (rx_cnt_q >= 8'd8) && (rx_cnt_q < 8'd128);
    end else begin
      rx_crc_en_s = (rx_cnt_q < 8'd40);
    end

    case (state_q)
      ST_IDLE: begin
        sd_cmd_oe_d = 1'b0;
        sd_cmd_o_d  = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d    = 1'b0;
          rtype_d        = resp_type;
          tx_sr_d        = {1'b0, 1'b1, cmd_index, cmd_arg};
          tx_crc_d       = 7'd0;
          tx_cnt_d       = 6'd0;
          rx_sr_d        = 136'd0;
          rx_crc_d       = 7'd0;
          rx_cnt_d       = 8'd0;
          wait_cnt_d     = '0;
          ncc_cnt_d      = '0;
          resp_timeout_d = 1'b0;
          resp_crc_err_d = 1'b0;
          resp_end_err_d = 1'b0;
          state_d        = ST_SEND;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (fall_ev_s) begin
          if (tx_cnt_q == 6'd48) begin
            sd_cmd_oe_d = 1'b0;
            sd_cmd_o_d  = 1'b1;
            state_d     = (rtype_q != 2'd0) ? ST_WAIT : ST_NCC;
          end else begin
            sd_cmd_oe_d = 1'b1;
            tx_cnt_d    = tx_cnt_q + 6'd1;
            if (tx_cnt_q < 6'd40) begin
              sd_cmd_o_d = tx_sr_q[39];
              tx_sr_d    = {tx_sr_q[38:0], 1'b0};
              tx_crc_d   = crc7_step(tx_crc_q, tx_sr_q[39]);
            end else if (tx_cnt_q < 6'd47) begin
              sd_cmd_o_d = tx_crc_q[6];
              tx_crc_d   = {tx_crc_q[5:0], 1'b0};
            end else begin
              sd_cmd_o_d = 1'b1;
            end
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (rise_ev_s) begin
          if (!sd_cmd_i) begin
            rx_sr_d  = {rx_sr_q[134:0], 1'b0};
            rx_crc_d = rx_crc_en_s ? crc7_step(rx_crc_q, 1'b0) : rx_crc_q;
            rx_cnt_d = 8'd1;
            state_d  = ST_RECV;
          end else if (wait_cnt_q == WAIT_W'(RESP_TIMEOUT - 1)) begin
            resp_timeout_d = 1'b1;
            state_d        = ST_NCC;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RECV: begin
        if (rx_cnt_q == rx_last_s) begin
          resp_end_err_d = ~rx_sr_q[0];
          if (rtype_q == 2'd3) begin
            resp_crc_err_d = 1'b0;
          end else begin
            resp_crc_err_d = (rx_crc_q != rx_sr_q[7:1]);
          end
          state_d = ST_NCC;
        end else if (rise_ev_s) begin
          rx_sr_d  = {rx_sr_q[134:0], sd_cmd_i};
          rx_crc_d = rx_crc_en_s ? crc7_step(rx_crc_q, sd_cmd_i) : rx_crc_q;
          rx_cnt_d = rx_cnt_q + 8'd1;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_NCC: begin
        if (rise_ev_s) begin
          if (ncc_cnt_q == NCC_W'(NCC_CYCLES - 1)) begin
            resp_valid_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            ncc_cnt_d = ncc_cnt_q + NCC_W'(1);
          end
        end else begin
          state_d = ST_NCC;
        end
      end
      ST_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        sd_cmd_oe_d = 1'b0;
        sd_cmd_o_d  = 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      div_cnt_q      <= '0;
      sd_clk_q       <= 1'b0;
      cmd_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_crc_err_q <= 1'b0;
      resp_end_err_q <= 1'b0;
      sd_cmd_o_q     <= 1'b1;
      sd_cmd_oe_q    <= 1'b0;
      rtype_q        <= 2'd0;
      tx_sr_q        <= 40'd0;
      tx_crc_q       <= 7'd0;
      tx_cnt_q       <= 6'd0;
      rx_sr_q        <= 136'd0;
      rx_crc_q       <= 7'd0;
      rx_cnt_q       <= 8'd0;
      wait_cnt_q     <= '0;
      ncc_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      sd_clk_q       <= sd_clk_d;
      cmd_ready_q    <= cmd_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_crc_err_q <= resp_crc_err_d;
      resp_end_err_q <= resp_end_err_d;
      sd_cmd_o_q     <= sd_cmd_o_d;
      sd_cmd_oe_q    <= sd_cmd_oe_d;
      rtype_q        <= rtype_d;
      tx_sr_q        <= tx_sr_d;
      tx_crc_q       <= tx_crc_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_sr_q        <= rx_sr_d;
      rx_crc_q       <= rx_crc_d;
      rx_cnt_q       <= rx_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      ncc_cnt_q      <= ncc_cnt_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = rx_sr_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_crc_err = resp_crc_err_q;
  assign resp_end_err = resp_end_err_q;
  assign sd_clk       = sd_clk_q;
  assign sd_cmd_o     = sd_cmd_o_q;
  assign sd_cmd_oe    = sd_cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: a card model answers on the CMD line and
// every observation is compared with values derived from SD frame rules.
module tb_sd_cmd_engine;

  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 64;
  localparam int NCC_CYCLES   = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [5:0]   cmd_index = 6'd0;
  logic [31:0]  cmd_arg = 32'd0;
  logic [1:0]   resp_type = 2'd0;
  logic         resp_valid;
  logic [135:0] resp_data;
  logic         resp_timeout, resp_crc_err, resp_end_err;
  logic         sd_clk, sd_cmd_o, sd_cmd_oe;
  logic         sd_cmd_i = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [47:0]  obs_frame;
  int           obs_nbits, obs_rises, obs_pulses;
  logic [135:0] obs_data;
  logic         obs_to, obs_crc, obs_end, obs_ready_bad, obs_done, obs_ready_after;

  always #5 clk = ~clk;

  sd_cmd_engine #(.CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .NCC_CYCLES(NCC_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .resp_crc_err(resp_crc_err), .resp_end_err(resp_end_err), .sd_clk(sd_clk),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .sd_cmd_i(sd_cmd_i)
  );

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1; message is v[n-1:0], MSB first.
  function automatic logic [6:0] ref_crc7(input logic [135:0] v, input int n);
    logic [7:0] r;
    r = 8'd0;
    for (int i = n - 1; i >= -7; i--) begin
      r = {r[6:0], (i >= 0) ? v[i] : 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, ref_crc7({96'd0, m}, 40), 1'b1};
  endfunction

  // Drives one command, records the frame, plays the card reply (rlen bits, start bit at
  // rise delay+1 after the frame end; rlen 0 = silent card) and captures the result.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                         input logic [135:0] reply, input int rlen, input int delay, input bit hold);
    bit prev, rise, ended;
    int cyc, pos;
    obs_frame = 48'd0; obs_nbits = 0; obs_rises = 0; obs_pulses = 0; obs_data = 136'd0;
    obs_to = 1'b0; obs_crc = 1'b0; obs_end = 1'b0; obs_ready_bad = 1'b0;
    obs_done = 1'b0; obs_ready_after = 1'b0; ended = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    cmd_index = idx; cmd_arg = arg; resp_type = rtype; cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    prev = sd_clk;
    for (cyc = 0; cyc < 20000 && !obs_done; cyc++) begin
      @(negedge clk);
      rise = sd_clk && !prev;
      prev = sd_clk;
      if (rise && sd_cmd_oe) begin
        if (obs_nbits < 48) obs_frame = {obs_frame[46:0], sd_cmd_o};
        obs_nbits++;
      end
      if (ended && rise) obs_rises++;
      if (!ended && obs_nbits >= 48 && !sd_cmd_oe) ended = 1'b1;
      if (resp_valid) begin
        obs_done = 1'b1; obs_pulses = 1; obs_data = resp_data;
        obs_to = resp_timeout; obs_crc = resp_crc_err; obs_end = resp_end_err;
        cmd_valid = 1'b0;
      end else if (cmd_ready) begin
        obs_ready_bad = 1'b1;
      end
      sd_cmd_i = 1'b1;
      if (ended && rlen > 0) begin
        pos = obs_rises - delay;
        if (pos >= 0 && pos < rlen) sd_cmd_i = reply[rlen - 1 - pos];
      end
    end
    sd_cmd_i = 1'b1;
    cmd_valid = 1'b0;
    if (obs_done) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (i == 0) obs_ready_after = cmd_ready;
        if (resp_valid) obs_pulses++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({cmd_ready, resp_valid, resp_timeout, resp_crc_err, resp_end_err, sd_clk, sd_cmd_o, sd_cmd_oe} !== 8'b1000_0010) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected %b", {cmd_ready, resp_valid, resp_timeout, resp_crc_err, resp_end_err, sd_clk, sd_cmd_o, sd_cmd_oe}, 8'b1000_0010);
    end
    tests_run++;
    if (resp_data !== 136'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", resp_data); end
  endtask

  task automatic test_divider();
    int n1, n2;
    rst = 1'b0;
    n1 = 0;
    while (sd_clk !== 1'b1 && n1 < 100) begin @(negedge clk); n1++; end
    n2 = 0;
    while (sd_clk !== 1'b0 && n2 < 100) begin @(negedge clk); n2++; end
    tests_run++;
    if (n1 !== CLK_DIV) begin tests_failed++; $display("FAIL div_first_rise: got %0d clks expected %0d", n1, CLK_DIV); end
    tests_run++;
    if (n2 !== CLK_DIV) begin tests_failed++; $display("FAIL div_half_period: got %0d clks expected %0d", n2, CLK_DIV); end
  endtask

  task automatic test_cmd0();
    run_txn(6'd0, 32'h0, 2'd0, 136'd0, 0, 0, 1'b0);
    tests_run++;
    if (obs_frame !== 48'h400000000095) begin tests_failed++; $display("FAIL cmd0_frame: got %h expected %h", obs_frame, 48'h400000000095); end
    tests_run++;
    if (obs_nbits !== 48) begin tests_failed++; $display("FAIL cmd0_nbits: got %0d expected 48", obs_nbits); end
    tests_run++;
    if (obs_done !== 1'b1 || obs_rises !== NCC_CYCLES) begin tests_failed++; $display("FAIL cmd0_ncc: done %b rises %0d expected 1 %0d", obs_done, obs_rises, NCC_CYCLES); end
    tests_run++;
    if ({obs_to, obs_crc, obs_end} !== 3'b000 || obs_data !== 136'd0) begin tests_failed++; $display("FAIL cmd0_flags: got %b data %h expected 000 0", {obs_to, obs_crc, obs_end}, obs_data); end
    tests_run++;
    if (obs_ready_after !== 1'b1 || obs_ready_bad !== 1'b0 || obs_pulses !== 1) begin tests_failed++; $display("FAIL cmd0_handshake: ready_after %b ready_bad %b pulses %0d expected 1 0 1", obs_ready_after, obs_ready_bad, obs_pulses); end
  endtask

  task automatic test_r1();
    logic [135:0] rep;
    rep = {88'd0, 48'h08000001AA13};
    run_txn(6'd8, 32'h000001AA, 2'd1, rep, 48, 5, 1'b0);
    tests_run++;
    if (obs_frame !== 48'h48000001AA87) begin tests_failed++; $display("FAIL cmd8_frame: got %h expected %h", obs_frame, 48'h48000001AA87); end
    tests_run++;
    if (obs_data !== rep || {obs_to, obs_crc, obs_end} !== 3'b000) begin tests_failed++; $display("FAIL cmd8_resp: got %h flags %b expected %h 000", obs_data, {obs_to, obs_crc, obs_end}, rep); end
    tests_run++;
    if (obs_rises !== 5 + 48 + NCC_CYCLES) begin tests_failed++; $display("FAIL cmd8_latency: got %0d rises expected %0d", obs_rises, 5 + 48 + NCC_CYCLES); end
    rep[20] = ~rep[20];
    run_txn(6'd8, 32'h000001AA, 2'd1, rep, 48, 5, 1'b0);
    tests_run++;
    if (obs_data !== rep || {obs_to, obs_crc, obs_end} !== 3'b010) begin tests_failed++; $display("FAIL cmd8_crc_err: got %h flags %b expected %h 010", obs_data, {obs_to, obs_crc, obs_end}, rep); end
    rep = {88'd0, 48'h08000001AA12};
    run_txn(6'd8, 32'h000001AA, 2'd1, rep, 48, 5, 1'b0);
    tests_run++;
    if (obs_data !== rep || {obs_to, obs_crc, obs_end} !== 3'b001) begin tests_failed++; $display("FAIL cmd8_end_err: got %h flags %b expected %h 001", obs_data, {obs_to, obs_crc, obs_end}, rep); end
  endtask

  task automatic test_r3();
    logic [135:0] rep;
    rep = {88'd0, 48'h3F00FF8000FF};
    run_txn(6'd41, 32'h40FF8000, 2'd3, rep, 48, 2, 1'b0);
    tests_run++;
    if (obs_frame !== ref_frame(6'd41, 32'h40FF8000)) begin tests_failed++; $display("FAIL cmd41_frame: got %h expected %h", obs_frame, ref_frame(6'd41, 32'h40FF8000)); end
    tests_run++;
    if (obs_data !== rep || {obs_to, obs_crc, obs_end} !== 3'b000) begin tests_failed++; $display("FAIL cmd41_resp: got %h flags %b expected %h 000", obs_data, {obs_to, obs_crc, obs_end}, rep); end
  endtask

  task automatic test_timeout();
    logic [135:0] rep;
    run_txn(6'd55, 32'h0, 2'd1, 136'd0, 0, 0, 1'b0);
    tests_run++;
    if (obs_done !== 1'b1 || obs_rises !== RESP_TIMEOUT + NCC_CYCLES) begin tests_failed++; $display("FAIL timeout_latency: done %b rises %0d expected 1 %0d", obs_done, obs_rises, RESP_TIMEOUT + NCC_CYCLES); end
    tests_run++;
    if ({obs_to, obs_crc, obs_end} !== 3'b100 || obs_data !== 136'd0 || obs_pulses !== 1) begin tests_failed++; $display("FAIL timeout_flags: got %b data %h pulses %0d expected 100 0 1", {obs_to, obs_crc, obs_end}, obs_data, obs_pulses); end
    // Start bit on the very last rise before the limit must still be accepted.
    rep = {88'd0, 48'h08000001AA13};
    run_txn(6'd8, 32'h000001AA, 2'd1, rep, 48, RESP_TIMEOUT - 1, 1'b0);
    tests_run++;
    if (obs_data !== rep || {obs_to, obs_crc, obs_end} !== 3'b000 || obs_rises !== RESP_TIMEOUT - 1 + 48 + NCC_CYCLES) begin
      tests_failed++;
      $display("FAIL timeout_boundary: got %h flags %b rises %0d expected %h 000 %0d", obs_data, {obs_to, obs_crc, obs_end}, obs_rises, rep, RESP_TIMEOUT - 1 + 48 + NCC_CYCLES);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; resp_type = 2'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (sd_cmd_oe !== 1'b1 || cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_in_send: oe %b ready %b expected 1 0", sd_cmd_oe, cmd_ready); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({cmd_ready, resp_valid, resp_timeout, resp_crc_err, resp_end_err, sd_clk, sd_cmd_o, sd_cmd_oe} !== 8'b1000_0010 || resp_data !== 136'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b data %h expected 10000010 0", {cmd_ready, resp_valid, resp_timeout, resp_crc_err, resp_end_err, sd_clk, sd_cmd_o, sd_cmd_oe}, resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_valid || sd_cmd_oe || !cmd_ready) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [135:0] rep;
    run_txn(6'd0, 32'h0, 2'd0, 136'd0, 0, 0, 1'b1);
    tests_run++;
    if (obs_frame !== 48'h400000000095 || obs_nbits !== 48) begin tests_failed++; $display("FAIL hold_frame: got %h bits %0d expected %h 48", obs_frame, obs_nbits, 48'h400000000095); end
    tests_run++;
    if (obs_ready_bad !== 1'b0 || obs_pulses !== 1 || obs_done !== 1'b1) begin tests_failed++; $display("FAIL hold_single_accept: ready_bad %b pulses %0d done %b expected 0 1 1", obs_ready_bad, obs_pulses, obs_done); end
    rep = {88'd0, 48'h08000001AA13};
    run_txn(6'd8, 32'h000001AA, 2'd1, rep, 48, 0, 1'b0);
    tests_run++;
    if (obs_frame !== 48'h48000001AA87 || obs_data !== rep || obs_rises !== 48 + NCC_CYCLES) begin tests_failed++; $display("FAIL b2b_second: frame %h data %h rises %0d expected %h %h %0d", obs_frame, obs_data, obs_rises, 48'h48000001AA87, rep, 48 + NCC_CYCLES); end
  endtask

  task automatic test_random();
    logic [5:0]   idx;
    logic [31:0]  arg, a2;
    logic [1:0]   rt;
    logic [127:0] cid;
    logic [39:0]  body;
    logic [135:0] rep, exp_data;
    logic [2:0]   exp_flags;
    int           delay, rlen, fp, exp_rises;
    bit           silent, ce;
    for (int t = 0; t < 12; t++) begin
      idx = 6'($urandom); arg = $urandom; rt = 2'($urandom_range(0, 3));
      delay = $urandom_range(0, 10);
      silent = (rt != 2'd0) && ($urandom_range(0, 5) == 0);
      rep = 136'd0; rlen = 0;
      if (rt == 2'd2) begin
        cid = {$urandom, $urandom, $urandom, $urandom};
        rep = {8'h3F, cid[119:0], ref_crc7({16'd0, cid[119:0]}, 120), 1'b1};
        rlen = 136;
      end else if (rt != 2'd0) begin
        a2 = $urandom;
        body = {2'b00, idx, a2};
        rep = {88'd0, body, ref_crc7({96'd0, body}, 40), 1'b1};
        rlen = 48;
      end else begin
        rlen = 0;
      end
      if (rlen > 0 && $urandom_range(0, 2) == 0) begin
        fp = $urandom_range(0, rlen - 2);
        rep[fp] = ~rep[fp];
      end
      run_txn(idx, arg, rt, rep, silent ? 0 : rlen, delay, 1'b0);
      if (rt == 2'd1) ce = (ref_crc7(rep >> 8, 40) != rep[7:1]);
      else if (rt == 2'd2) ce = (ref_crc7(rep >> 8, 120) != rep[7:1]);
      else ce = 1'b0;
      if (rt == 2'd0) begin
        exp_data = 136'd0; exp_flags = 3'b000; exp_rises = NCC_CYCLES;
      end else if (silent) begin
        exp_data = 136'd0; exp_flags = 3'b100; exp_rises = RESP_TIMEOUT + NCC_CYCLES;
      end else begin
        exp_data = rep; exp_flags = {1'b0, ce, ~rep[0]}; exp_rises = delay + rlen + NCC_CYCLES;
      end
      tests_run++;
      if (obs_frame !== ref_frame(idx, arg) || obs_nbits !== 48) begin tests_failed++; $display("FAIL rand%0d_frame: got %h bits %0d expected %h 48", t, obs_frame, obs_nbits, ref_frame(idx, arg)); end
      tests_run++;
      if (obs_data !== exp_data || {obs_to, obs_crc, obs_end} !== exp_flags) begin tests_failed++; $display("FAIL rand%0d_resp: type %0d got %h flags %b expected %h %b", t, rt, obs_data, {obs_to, obs_crc, obs_end}, exp_data, exp_flags); end
      tests_run++;
      if (obs_done !== 1'b1 || obs_rises !== exp_rises || obs_pulses !== 1) begin tests_failed++; $display("FAIL rand%0d_timing: done %b rises %0d pulses %0d expected 1 %0d 1", t, obs_done, obs_rises, obs_pulses, exp_rises); end
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_cmd0();
    test_r1();
    test_r3();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1);
  end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
Parametrised SD/SDIO command-line engine; successor to the fixed single-command CMD5 sequencer. Accepts a command (index and argument) over a valid/ready handshake and serialises the 48-bit frame with a computed CRC7. It then receives an optional 48-bit or 136-bit response, checking its CRC and end bit, with timeout. It generates its own divided SD clock and sits between the board-level control FSM and the card pins (tristate buffer external).

Parameters:
CLK_DIV, 34, clk cycles per SD clock half-period (27 MHz / 68 ≈ 397 kHz identification rate); legal range ≥1.
RESP_TIMEOUT, 64, SD clock cycles to wait for the response start bit (NCR limit).
NCC_CYCLES, 8, idle SD clocks inserted after each transaction before cmd_ready reasserts.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle, can accept command
cmd_index  in  6  command index
cmd_arg  in  32  command argument
resp_type  in  2  0 none, 1 R1/R6/R7 (48b, CRC checked), 2 R2 (136b), 3 R3/R4 (48b, CRC ignored)
resp_valid  out  1  one-cycle pulse, transaction complete
resp_data  out  136  received frame, right-aligned; 48b responses in [47:0], upper bits zero
resp_timeout  out  1  no start bit within RESP_TIMEOUT, valid with resp_valid
resp_crc_err  out  1  CRC7 mismatch, valid with resp_valid
resp_end_err  out  1  end bit not 1, valid with resp_valid
sd_clk  out  1  SD clock
sd_cmd_o  out  1  CMD line drive value
sd_cmd_oe  out  1  CMD line output enable
sd_cmd_i  in  1  CMD line sampled value

Behaviour:
- Reset values: cmd_ready=1, resp_valid=0, resp_data=0, all error flags=0, sd_clk=0, sd_cmd_o=1, sd_cmd_oe=0, state IDLE, divider=0. Reset mid-transaction aborts immediately; no resp_valid.
- Divider: counter 0..CLK_DIV-1 runs continuously; at terminal count sd_clk toggles. A toggle 0→1 is a "rise" event; 1→0 is a "fall" event. Host changes sd_cmd_o only on fall events. sd_cmd_i is sampled only on rise events.
- Handshake: command accepted in the clk cycle where cmd_valid && cmd_ready. index, arg and resp_type are latched; cmd_ready drops the next cycle. cmd_valid while cmd_ready=0 is ignored.
- Frame: {0, 1, index[5:0], arg[31:0], crc7[6:0], 1}, MSB first. CRC7 polynomial x^7+x^3+1, init 0, over the first 40 bits. It is computed serially while shifting.
- States:
  - IDLE: oe=0, o=1. On accept → SEND.
  - SEND: oe=1 from the first fall event. One bit per fall event, 48 bits. On the fall event after bit 0: oe=0, then → WAIT if resp_type≠0, else → NCC.
  - WAIT: on each rise event, if sd_cmd_i=0 then that is the start bit; store it and → RECV. Otherwise increment the counter. When the counter reaches RESP_TIMEOUT, set resp_timeout=1 → NCC.
  - RECV: shift in one bit per rise event until 48 (types 1,3) or 136 (type 2) bits total, including the start bit. Then evaluate:
    - resp_end_err = (bit0≠1).
    - CRC for type 1 is over bits [47:8] vs [7:1].
    - CRC for type 2 is over bits [127:8] vs [7:1].
    - Type 3: resp_crc_err forced 0.
    - Then → NCC.
  - NCC: count NCC_CYCLES rise events with oe=0, then → DONE.
  - DONE: resp_valid=1 for one clk, error flags held until the next accept. cmd_ready=1 the following cycle → IDLE.
- resp_data and flags are cleared on each accept. resp_data is undefined-free: unreceived bits are 0.
- resp_type=0: resp_valid still pulses after NCC, with all flags 0.

Test Plan:
- CMD0, arg 0x00000000, resp_type 0 → 48 bits on sd_cmd_o = 0x400000000095, oe low after last bit. resp_valid after 8 idle SD clocks, flags 0.
- CMD8, arg 0x000001AA, resp_type 1, card model replies 0x08000001AA13 after 5 SD clocks → frame 0x48000001AA87 sent. resp_data[47:0]=0x08000001AA13, crc_err=0, end_err=0.
- Same as previous scenario, but the model flips response bit 20 → resp_crc_err=1. Second variant: last bit 0 → resp_end_err=1.
- CMD41 arg 0x40FF8000, resp_type 3, reply 0x3F00FF8000FF → resp_data matches, crc_err=0 despite invalid CRC.
- resp_type 1 with card silent (sd_cmd_i=1) → resp_timeout=1 exactly 64 rise events after the frame end. resp_valid pulses once.
- Assert rst mid-SEND, then issue CMD0 → outputs at reset values immediately. Next transaction produces the correct 0x400000000095. cmd_valid held high during a transaction causes no second accept.
